// File: rtl/axi_adapter_arbiter_pkg.sv
// Shared types for the AXI adapter arbiter: request kind, arbiter states and
// the wrap-around helper used by the round-robin search and pointer update.
package axi_adapter_arbiter_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic {
    SINGLE_REQ     = 1'b0,
    CACHE_LINE_REQ = 1'b1
  } ad_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_REQ      = 2'd1,
    ARB_WAIT_RSP = 2'd2
  } arb_state_e;

  // Modulo add by explicit compare so non-power-of-two port counts wrap correctly.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/axi_adapter_arbiter_if.sv
// Requester-side and adapter-side bus of the arbiter; the arbiter takes the
// slave view, requesters plus adapter take the master view.
interface axi_adapter_arbiter_if
  import axi_adapter_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 3,
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned AXI_ID_WIDTH = 10
);
  localparam int unsigned NW = DATA_WIDTH / XLEN;

  logic    [NUM_PORTS-1:0]                     req_i;
  ad_req_t [NUM_PORTS-1:0]                     type_i;
  logic    [NUM_PORTS-1:0][XLEN-1:0]           addr_i;
  logic    [NUM_PORTS-1:0]                     we_i;
  logic    [NUM_PORTS-1:0][NW-1:0][XLEN-1:0]   wdata_i;
  logic    [NUM_PORTS-1:0][NW-1:0][XLEN/8-1:0] be_i;
  logic    [NUM_PORTS-1:0][1:0]                size_i;
  logic    [NUM_PORTS-1:0][AXI_ID_WIDTH-1:0]   id_i;
  logic    [NUM_PORTS-1:0]                     gnt_o;
  logic    [NUM_PORTS-1:0]                     valid_o;
  logic    [NW-1:0][XLEN-1:0]                  rdata_o;
  logic    [AXI_ID_WIDTH-1:0]                  id_o;

  logic                                        adapter_req_o;
  ad_req_t                                     adapter_type_o;
  logic    [XLEN-1:0]                          adapter_addr_o;
  logic                                        adapter_we_o;
  logic    [NW-1:0][XLEN-1:0]                  adapter_wdata_o;
  logic    [NW-1:0][XLEN/8-1:0]                adapter_be_o;
  logic    [1:0]                               adapter_size_o;
  logic    [AXI_ID_WIDTH-1:0]                  adapter_id_o;
  logic                                        adapter_gnt_i;
  logic                                        adapter_valid_i;
  logic    [NW-1:0][XLEN-1:0]                  adapter_rdata_i;
  logic    [AXI_ID_WIDTH-1:0]                  adapter_id_i;
  logic                                        busy_o;

  modport slave (
    input  req_i, type_i, addr_i, we_i, wdata_i, be_i, size_i, id_i,
    input  adapter_gnt_i, adapter_valid_i, adapter_rdata_i, adapter_id_i,
    output gnt_o, valid_o, rdata_o, id_o, busy_o,
    output adapter_req_o, adapter_type_o, adapter_addr_o, adapter_we_o,
    output adapter_wdata_o, adapter_be_o, adapter_size_o, adapter_id_o
  );

  modport master (
    output req_i, type_i, addr_i, we_i, wdata_i, be_i, size_i, id_i,
    output adapter_gnt_i, adapter_valid_i, adapter_rdata_i, adapter_id_i,
    input  gnt_o, valid_o, rdata_o, id_o, busy_o,
    input  adapter_req_o, adapter_type_o, adapter_addr_o, adapter_we_o,
    input  adapter_wdata_o, adapter_be_o, adapter_size_o, adapter_id_o
  );

endinterface

// File: rtl/axi_adapter_arbiter_rr_pick.sv
// Combinational round-robin search: first asserted request at or above ptr_i,
// wrapping around; any_o flags that some request is present.
module axi_adapter_arbiter_rr_pick
  import axi_adapter_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     winner,
  output logic                 any
);

  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!any && req[IDX_W'(rr_wrap(32'(ptr), i, NUM_PORTS))]) begin
        any    = 1'b1;
        winner = IDX_W'(rr_wrap(32'(ptr), i, NUM_PORTS));
      end
    end
  end

endmodule

// File: rtl/axi_adapter_arbiter.sv
// Round-robin arbiter serialising NUM_PORTS requesters onto one AXI adapter port,
// one transaction in flight; grant and completion are combinational pass-throughs.
module axi_adapter_arbiter
  import axi_adapter_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 3,
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned AXI_ID_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  axi_adapter_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       winner, sel;
  logic                   any_req, mux_en;
  logic                   adapter_req;
  logic [NUM_PORTS-1:0]   gnt, vld;
  logic [DATA_WIDTH-1:0]  rdata;
  logic [AXI_ID_WIDTH-1:0] rsp_id;

  axi_adapter_arbiter_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .req    (bus.req_i),
    .ptr    (rr_q),
    .winner (winner),
    .any    (any_req)
  );

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] cur);
    return IDX_W'(rr_wrap(32'(cur), 1, NUM_PORTS));
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    sel         = owner_q;
    adapter_req = 1'b0;
    gnt         = '0;
    vld         = '0;
    rdata       = '0;
    rsp_id      = '0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          sel          = winner;
          owner_d      = winner;
          adapter_req  = 1'b1;
          gnt[winner]  = bus.adapter_gnt_i;
          if (bus.adapter_gnt_i) begin
            state_d = ARB_WAIT_RSP;
            rr_d    = next_ptr(winner);
          end else begin
            state_d = ARB_REQ;
          end
        end
      end
      // Locked to the owner: a newly asserting port must wait its turn.
      ARB_REQ: begin
        adapter_req  = 1'b1;
        gnt[owner_q] = bus.adapter_gnt_i;
        if (bus.adapter_gnt_i) begin
          state_d = ARB_WAIT_RSP;
          rr_d    = next_ptr(owner_q);
        end
      end
      ARB_WAIT_RSP: begin
        vld[owner_q] = bus.adapter_valid_i;
        rdata        = bus.adapter_rdata_i;
        rsp_id       = bus.adapter_id_i;
        if (bus.adapter_valid_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Mux held on the owner through WAIT_RSP since the adapter samples fields after grant.
  assign mux_en = (state_q != ARB_IDLE) || any_req;

  assign bus.adapter_req_o   = adapter_req;
  assign bus.adapter_type_o  = mux_en ? bus.type_i[sel]  : SINGLE_REQ;
  assign bus.adapter_addr_o  = mux_en ? bus.addr_i[sel]  : '0;
  assign bus.adapter_we_o    = mux_en ? bus.we_i[sel]    : 1'b0;
  assign bus.adapter_wdata_o = mux_en ? bus.wdata_i[sel] : '0;
  assign bus.adapter_be_o    = mux_en ? bus.be_i[sel]    : '0;
  assign bus.adapter_size_o  = mux_en ? bus.size_i[sel]  : '0;
  assign bus.adapter_id_o    = mux_en ? bus.id_i[sel]    : '0;

  assign bus.gnt_o   = gnt;
  assign bus.valid_o = vld;
  assign bus.rdata_o = rdata;
  assign bus.id_o    = rsp_id;
  assign bus.busy_o  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_axi_adapter_arbiter.sv
// Scoreboard bench: adapter model plus requester tasks; expected grants and
// completions are queued at stimulus time and checked at the falling edge.
module tb_axi_adapter_arbiter;
  import axi_adapter_arbiter_pkg::*;

  localparam int unsigned NP  = 3;
  localparam int unsigned DW  = 256;
  localparam int unsigned IDW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_adapter_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW)) bus ();

  axi_adapter_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int             port;
    logic [63:0]    addr;
    logic [IDW-1:0] id;
    logic           we;
    ad_req_t        typ;
    logic [DW-1:0]  wdata;
  } exp_t;

  exp_t gnt_q[$];
  exp_t rsp_q[$];
  exp_t cur;

  int n_checks = 0;
  int n_errors = 0;

  int   gnt_delay;
  int   rsp_delay;
  logic stray;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] line_data(input logic [63:0] addr);
    logic [DW-1:0] r;
    for (int w = 0; w < DW / 64; w++) r[w*64 +: 64] = (addr + 64'(w)) ^ 64'hA5A5_0000_5A5A_0000;
    return r;
  endfunction

  task automatic expect_txn(input int p, input logic [63:0] addr, input logic [IDW-1:0] id,
                            input logic we, input ad_req_t typ, input logic [DW-1:0] wdata,
                            input bit rsp);
    exp_t e;
    e.port = p; e.addr = addr; e.id = id; e.we = we; e.typ = typ; e.wdata = wdata;
    gnt_q.push_back(e);
    if (rsp) rsp_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the edge following the grant.
  task automatic issue(input int p, input logic [63:0] addr, input logic [IDW-1:0] id,
                       input logic we, input ad_req_t typ, input logic [DW-1:0] wdata);
    int n;
    bus.type_i[p]  = typ;
    bus.addr_i[p]  = addr;
    bus.we_i[p]    = we;
    bus.wdata_i[p] = wdata;
    bus.be_i[p]    = we ? '1 : '0;
    bus.size_i[p]  = 2'd3;
    bus.id_i[p]    = id;
    bus.req_i[p]   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.gnt_o[p] && n < 200);
    chk("gnt_seen", bus.gnt_o[p], 1'b1);
    @(posedge clk); #1;
    bus.req_i[p] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || gnt_q.size() != 0 || bus.busy_o) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_rsp_q", rsp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Adapter model: grants after gnt_delay cycles, completes rsp_delay cycles later.
  initial begin
    int          m_wait, m_cnt;
    logic        m_busy;
    logic [63:0] m_addr;
    logic [IDW-1:0] m_id;
    bus.adapter_gnt_i   = 1'b0;
    bus.adapter_valid_i = 1'b0;
    bus.adapter_rdata_i = '0;
    bus.adapter_id_i    = '0;
    m_wait = 0; m_cnt = 0; m_busy = 1'b0; m_addr = '0; m_id = '0;
    forever begin
      @(posedge clk); #2;
      bus.adapter_gnt_i   = 1'b0;
      bus.adapter_valid_i = 1'b0;
      bus.adapter_rdata_i = '0;
      bus.adapter_id_i    = '0;
      if (rst) begin
        m_busy = 1'b0; m_wait = 0; m_cnt = 0;
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt >= rsp_delay) begin
          bus.adapter_valid_i = 1'b1;
          bus.adapter_rdata_i = line_data(m_addr);
          bus.adapter_id_i    = m_id;
          m_busy = 1'b0;
        end
      end else if (stray) begin
        bus.adapter_valid_i = 1'b1;
        bus.adapter_rdata_i = '1;
        bus.adapter_id_i    = '1;
      end else if (bus.adapter_req_o) begin
        if (m_wait >= gnt_delay) begin
          bus.adapter_gnt_i = 1'b1;
          m_addr = bus.adapter_addr_o;
          m_id   = bus.adapter_id_o;
          m_busy = 1'b1; m_cnt = 0; m_wait = 0;
        end else begin
          m_wait++;
        end
      end
    end
  end

  // Monitor: request mux, grant order, pointer, held fields and completions.
  initial begin
    logic          rr_pend;
    int            exp_rr;
    exp_t          e;
    logic [NP-1:0] oh;
    rr_pend = 1'b0;
    exp_rr  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rr_pend = 1'b0;
        continue;
      end
      if (rr_pend) begin
        chk("rr_ptr", dut.rr_q, exp_rr);
        rr_pend = 1'b0;
      end
      if (bus.adapter_req_o) begin
        if (gnt_q.size() == 0) chk("req_unexpected", bus.adapter_req_o, 1'b0);
        else begin
          chk("req_addr", bus.adapter_addr_o, gnt_q[0].addr);
          chk("req_id", bus.adapter_id_o, gnt_q[0].id);
          chk("req_we", bus.adapter_we_o, gnt_q[0].we);
          chk("req_type", bus.adapter_type_o, gnt_q[0].typ);
        end
      end else if (bus.busy_o) begin
        chk("hold_addr", bus.adapter_addr_o, cur.addr);
        chk("hold_wdata", bus.adapter_wdata_o, cur.wdata);
      end
      if (bus.gnt_o != '0) begin
        if (gnt_q.size() == 0) chk("gnt_unexpected", bus.gnt_o, '0);
        else begin
          e = gnt_q.pop_front();
          oh = '0;
          oh[e.port] = 1'b1;
          chk("gnt_onehot", bus.gnt_o, oh);
          cur     = e;
          exp_rr  = (e.port + 1) % NP;
          rr_pend = 1'b1;
        end
      end
      if (bus.valid_o != '0) begin
        if (rsp_q.size() == 0) chk("valid_unexpected", bus.valid_o, '0);
        else begin
          e = rsp_q.pop_front();
          oh = '0;
          oh[e.port] = 1'b1;
          chk("valid_onehot", bus.valid_o, oh);
          chk("rsp_id", bus.id_o, e.id);
          chk("rsp_rdata", bus.rdata_o, line_data(e.addr));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] line_wd;
    rst = 1'b1;
    gnt_delay = 0;
    rsp_delay = 1;
    stray = 1'b0;
    bus.req_i = '0; bus.type_i = '{default: SINGLE_REQ}; bus.addr_i = '0; bus.we_i = '0;
    bus.wdata_i = '0; bus.be_i = '0; bus.size_i = '0; bus.id_i = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", bus.gnt_o, '0);
    chk("rst_valid", bus.valid_o, '0);
    chk("rst_adapter_req", bus.adapter_req_o, 1'b0);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_rdata", bus.rdata_o, '0);
    chk("rst_id", bus.id_o, '0);
    chk("rst_state", dut.state_q, ARB_IDLE);
    chk("rst_rr", dut.rr_q, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single read on port 1, granted in the request cycle.
    expect_txn(1, 64'h8000_0010, 10'h005, 1'b0, SINGLE_REQ, '0, 1'b1);
    issue(1, 64'h8000_0010, 10'h005, 1'b0, SINGLE_REQ, '0);
    drain();

    // All three ports at once from reset; port 0 re-requests afterwards.
    pulse_reset();
    expect_txn(0, 64'h1000_0000, 10'h010, 1'b0, SINGLE_REQ, '0, 1'b1);
    expect_txn(1, 64'h1000_0100, 10'h011, 1'b0, CACHE_LINE_REQ, '0, 1'b1);
    expect_txn(2, 64'h1000_0200, 10'h012, 1'b0, SINGLE_REQ, '0, 1'b1);
    expect_txn(0, 64'h1000_0300, 10'h013, 1'b0, SINGLE_REQ, '0, 1'b1);
    fork
      begin
        issue(0, 64'h1000_0000, 10'h010, 1'b0, SINGLE_REQ, '0);
        @(posedge clk); #1;
        issue(0, 64'h1000_0300, 10'h013, 1'b0, SINGLE_REQ, '0);
      end
      issue(1, 64'h1000_0100, 10'h011, 1'b0, CACHE_LINE_REQ, '0);
      issue(2, 64'h1000_0200, 10'h012, 1'b0, SINGLE_REQ, '0);
    join
    drain();

    // Delayed grant: port 2 holds the mux while port 0 arrives mid-wait.
    gnt_delay = 4;
    expect_txn(2, 64'h2000_0040, 10'h020, 1'b0, SINGLE_REQ, '0, 1'b1);
    expect_txn(0, 64'h2000_0080, 10'h021, 1'b0, SINGLE_REQ, '0, 1'b1);
    fork
      issue(2, 64'h2000_0040, 10'h020, 1'b0, SINGLE_REQ, '0);
      begin
        repeat (2) @(posedge clk);
        #1;
        issue(0, 64'h2000_0080, 10'h021, 1'b0, SINGLE_REQ, '0);
      end
    join
    drain();

    // Cache-line write on port 0 with a late grant and slow completion.
    gnt_delay = 5;
    rsp_delay = 3;
    line_wd = {64'h44, 64'h33, 64'h22, 64'h11};
    expect_txn(0, 64'h8000_1000, 10'h02A, 1'b1, CACHE_LINE_REQ, line_wd, 1'b1);
    issue(0, 64'h8000_1000, 10'h02A, 1'b1, CACHE_LINE_REQ, line_wd);
    drain();
    gnt_delay = 0;

    // Reset while waiting for the response abandons the transaction.
    rsp_delay = 20;
    expect_txn(2, 64'h3000_0000, 10'h030, 1'b0, SINGLE_REQ, '0, 1'b0);
    issue(2, 64'h3000_0000, 10'h030, 1'b0, SINGLE_REQ, '0);
    chk("mid_busy", bus.busy_o, 1'b1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", bus.gnt_o, '0);
    chk("mid_rst_valid", bus.valid_o, '0);
    chk("mid_rst_adapter_req", bus.adapter_req_o, 1'b0);
    chk("mid_rst_busy", bus.busy_o, 1'b0);
    chk("mid_rst_rdata", bus.rdata_o, '0);
    chk("mid_rst_id", bus.id_o, '0);
    chk("mid_rst_state", dut.state_q, ARB_IDLE);
    @(posedge clk); #3;
    rst = 1'b0;
    rsp_delay = 1;
    @(posedge clk); #1;
    expect_txn(1, 64'h3000_0100, 10'h031, 1'b0, SINGLE_REQ, '0, 1'b1);
    issue(1, 64'h3000_0100, 10'h031, 1'b0, SINGLE_REQ, '0);
    drain();

    // Completion from the adapter while idle must not reach any requester.
    stray = 1'b1;
    @(negedge clk);
    chk("stray_adapter_valid", bus.adapter_valid_i, 1'b1);
    chk("stray_valid", bus.valid_o, '0);
    chk("stray_id", bus.id_o, '0);
    chk("stray_busy", bus.busy_o, 1'b0);
    @(posedge clk); #1;
    stray = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    chk("gnt_q_empty", gnt_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
